// File: rtl/rank_pipe_pkg.sv
// Shared types and constants for the rank-pipe sharers: default widths,
// the output-slot state encoding and the stats counter width.
package rank_pipe_pkg;

    localparam int unsigned NUM_PORTS_DEF     = 4;
    localparam int unsigned FLOW_ID_WIDTH_DEF = 16;
    localparam int unsigned META_WIDTH_DEF    = 16;
    localparam int unsigned RANK_WIDTH_DEF    = FLOW_ID_WIDTH_DEF;
    localparam int unsigned RR_PTR_W          = $clog2(NUM_PORTS_DEF);
    localparam int unsigned STATS_W           = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rm_state_e;

    // One rank-stage entry as seen at the head / output slot
    typedef struct packed {
        logic [RANK_WIDTH_DEF-1:0] rank;
        logic [META_WIDTH_DEF-1:0] meta;
    } rank_entry_t;

endpackage

// File: rtl/rank_insert_arbiter_if.sv
// Bus bundle between the ingress requesters / rank stage / PIFO and the arbiter.
// grant_count and stats_clr exist only when RANK_ARB_STATS_EN is defined.
interface rank_insert_arbiter_if #(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned FLOW_ID_WIDTH = 16,
    parameter int unsigned META_WIDTH    = 16,
    parameter int unsigned RANK_WIDTH    = 16
);
    logic [NUM_PORTS-1:0]               req_valid;
    logic [NUM_PORTS-1:0]               req_ready;
    logic [NUM_PORTS*FLOW_ID_WIDTH-1:0] req_flowID;
    logic [NUM_PORTS*META_WIDTH-1:0]    req_meta;
    logic                               rank_insert;
    logic [FLOW_ID_WIDTH-1:0]           rank_flowID;
    logic [META_WIDTH-1:0]              rank_meta_wr;
    logic                               rank_busy;
    logic                               rank_valid;
    logic [RANK_WIDTH-1:0]              rank_rank;
    logic [META_WIDTH-1:0]              rank_meta_rd;
    logic                               rank_remove;
    logic                               out_valid;
    logic                               out_ready;
    logic [RANK_WIDTH-1:0]              out_rank;
    logic [META_WIDTH-1:0]              out_meta;
`ifdef RANK_ARB_STATS_EN
    logic [NUM_PORTS*32-1:0]            grant_count;
    logic                               stats_clr;
`endif

    modport slave (
        input  req_valid, req_flowID, req_meta, rank_busy, rank_valid,
               rank_rank, rank_meta_rd, out_ready,
`ifdef RANK_ARB_STATS_EN
        input  stats_clr,
        output grant_count,
`endif
        output req_ready, rank_insert, rank_flowID, rank_meta_wr,
               rank_remove, out_valid, out_rank, out_meta
    );

    modport master (
        output req_valid, req_flowID, req_meta, rank_busy, rank_valid,
               rank_rank, rank_meta_rd, out_ready,
`ifdef RANK_ARB_STATS_EN
        output stats_clr,
        input  grant_count,
`endif
        input  req_ready, rank_insert, rank_flowID, rank_meta_wr,
               rank_remove, out_valid, out_rank, out_meta
    );

endinterface

// File: rtl/rank_insert_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after rr_ptr (wrapping).
module rr_arbiter
    import rank_pipe_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned PTR_W     = RR_PTR_W
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic [NUM_PORTS-1:0] grant_c_o,
    output logic [PTR_W-1:0]     win_c_o,
    output logic                 valid_c_o
);

    logic [PTR_W-1:0] idx_c;

    always_comb begin
        grant_c_o = '0;
        win_c_o   = '0;
        valid_c_o = 1'b0;
        idx_c     = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx_c = PTR_W'((32'(rr_ptr_i) + k) % NUM_PORTS);
            if (!valid_c_o && req_i[idx_c]) begin
                valid_c_o        = 1'b1;
                grant_c_o[idx_c] = 1'b1;
                win_c_o          = idx_c;
            end
        end
    end

endmodule

// File: rtl/rank_insert_arbiter.sv
// Round-robin insert arbiter plus one-entry registered drain slot for a shared rank stage.
// Optional per-port grant counters are built when RANK_ARB_STATS_EN is defined.
module rank_insert_arbiter
    import rank_pipe_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = NUM_PORTS_DEF,
    parameter int unsigned FLOW_ID_WIDTH = FLOW_ID_WIDTH_DEF,
    parameter int unsigned META_WIDTH    = META_WIDTH_DEF,
    parameter int unsigned RANK_WIDTH    = RANK_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    rank_insert_arbiter_if.slave arb_if
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // ---------------- insert side ----------------
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] arb_grant_c;
    logic [PTR_W-1:0]     arb_win_c;
    logic                 arb_valid_c;
    logic                 grant_c;
    logic [NUM_PORTS-1:0] req_ready_c;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_arbiter (
        .req_i     (arb_if.req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .grant_c_o (arb_grant_c),
        .win_c_o   (arb_win_c),
        .valid_c_o (arb_valid_c)
    );

    // Busy or reset masks the grant entirely, so the pointer keeps its place
    always_comb begin
        grant_c     = rst_n & ~arb_if.rank_busy & arb_valid_c;
        req_ready_c = grant_c ? arb_grant_c : '0;
        rr_ptr_d    = rr_ptr_q;
        if (grant_c) begin
            rr_ptr_d = (arb_win_c == PTR_W'(NUM_PORTS - 1)) ? '0 : arb_win_c + PTR_W'(1);
        end
    end

    assign arb_if.req_ready    = req_ready_c;
    assign arb_if.rank_insert  = grant_c;
    assign arb_if.rank_flowID  = grant_c ?
        arb_if.req_flowID[32'(arb_win_c) * FLOW_ID_WIDTH +: FLOW_ID_WIDTH] : '0;
    assign arb_if.rank_meta_wr = grant_c ?
        arb_if.req_meta[32'(arb_win_c) * META_WIDTH +: META_WIDTH] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ---------------- remove side ----------------
    rm_state_e              state_q, state_d;
    logic [RANK_WIDTH-1:0]  out_rank_q, out_rank_d;
    logic [META_WIDTH-1:0]  out_meta_q, out_meta_d;
    logic                   remove_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_rank_q <= '0;
            out_meta_q <= '0;
        end else begin
            state_q    <= state_d;
            out_rank_q <= out_rank_d;
            out_meta_q <= out_meta_d;
        end
    end

    // Pop the head whenever the slot is empty or is being drained this cycle
    always_comb begin
        state_d    = state_q;
        out_rank_d = out_rank_q;
        out_meta_d = out_meta_q;
        remove_c   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (arb_if.rank_valid) begin
                    remove_c = 1'b1;
                    state_d  = ST_FULL;
                end
            end
            ST_FULL: begin
                if (arb_if.out_ready) begin
                    if (arb_if.rank_valid) begin
                        remove_c = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        remove_c = remove_c & rst_n;
        if (remove_c) begin
            out_rank_d = arb_if.rank_rank;
            out_meta_d = arb_if.rank_meta_rd;
        end
    end

    assign arb_if.rank_remove = remove_c;
    assign arb_if.out_valid   = (state_q == ST_FULL);
    assign arb_if.out_rank    = out_rank_q;
    assign arb_if.out_meta    = out_meta_q;

`ifdef RANK_ARB_STATS_EN
    // ---------------- per-port grant counters ----------------
    logic [STATS_W-1:0] cnt_q [NUM_PORTS];
    logic [STATS_W-1:0] cnt_d [NUM_PORTS];

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (arb_if.stats_clr) begin
                cnt_d[i] = '0;
            end else if (req_ready_c[i] && arb_if.req_valid[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + STATS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
        assign arb_if.grant_count[g*STATS_W +: STATS_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_rank_insert_arbiter.sv
// Bench for rank_insert_arbiter: queue-based rank stage, spec-level model and
// scoreboard, with directed literal checks followed by randomized traffic.
module tb_rank_insert_arbiter;
    import rank_pipe_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned FW = 16;
    localparam int unsigned MW = 16;
    localparam int unsigned RW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rank_insert_arbiter_if #(.NUM_PORTS(NP), .FLOW_ID_WIDTH(FW), .META_WIDTH(MW), .RANK_WIDTH(RW)) bus ();

    rank_insert_arbiter #(
        .NUM_PORTS(NP), .FLOW_ID_WIDTH(FW), .META_WIDTH(MW), .RANK_WIDTH(RW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state
    int              m_ptr;
    bit              m_full;
    logic [RW-1:0]   m_rank;
    logic [MW-1:0]   m_meta;
    rank_entry_t     sq[$];
    rank_entry_t     gold[$];
    logic [FW-1:0]   fid [NP];
    logic [MW-1:0]   meta[NP];
`ifdef RANK_ARB_STATS_EN
    logic [31:0]     m_cnt[NP];
`endif

    // DUT values seen at the last step's sample point
    logic [NP-1:0]   last_ready;
    logic            last_insert;
    logic [FW-1:0]   last_fid;
    logic            last_remove;
    logic            last_out_valid;
    logic [RW-1:0]   last_out_rank;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [RW-1:0] r, input logic [MW-1:0] m);
        rank_entry_t e;
        e.rank = r;
        e.meta = m;
        sq.push_back(e);
        gold.push_back(e);
    endtask

    task automatic drive_stage();
        bus.rank_valid   = (sq.size() > 0);
        bus.rank_rank    = (sq.size() > 0) ? sq[0].rank : '0;
        bus.rank_meta_rd = (sq.size() > 0) ? sq[0].meta : '0;
        for (int i = 0; i < NP; i++) begin
            bus.req_flowID[i*FW +: FW] = fid[i];
            bus.req_meta[i*MW +: MW]   = meta[i];
        end
    endtask

    // One clock: compare everything against the model, then advance model and stage
    task automatic step(output int win);
        logic [NP-1:0] e_ready;
        logic [FW-1:0] e_fid;
        logic [MW-1:0] e_meta;
        logic          e_rem;
        bit            acc;
        logic          ins_a, rem_a;
        logic [FW-1:0] fid_a;
        logic [MW-1:0] meta_a;
        rank_entry_t   e, head;
        drive_stage();
        #1;
        win = -1;
        if (!bus.rank_busy) begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_ptr + k) % NP;
                if (win < 0 && bus.req_valid[p]) win = p;
            end
        end
        e_ready = '0;
        e_fid   = '0;
        e_meta  = '0;
        if (win >= 0) begin
            e_ready[win] = 1'b1;
            e_fid        = fid[win];
            e_meta       = meta[win];
        end
        chk("req_ready", bus.req_ready, e_ready);
        chk("rank_insert", bus.rank_insert, (win >= 0));
        chk("rank_flowID", bus.rank_flowID, e_fid);
        chk("rank_meta_wr", bus.rank_meta_wr, e_meta);
        e_rem = (sq.size() > 0) && (!m_full || bus.out_ready);
        chk("rank_remove", bus.rank_remove, e_rem);
        chk("out_valid", bus.out_valid, m_full);
        if (m_full) begin
            chk("out_rank", bus.out_rank, m_rank);
            chk("out_meta", bus.out_meta, m_meta);
        end
        acc = m_full && bus.out_ready;
        if (acc) begin
            if (gold.size() == 0) begin
                total++;
                bad++;
                $display("FAIL order actual=%0h required=none t=%0t", bus.out_rank, $time);
            end else begin
                e = gold.pop_front();
                chk("order_rank", bus.out_rank, e.rank);
            end
        end
`ifdef RANK_ARB_STATS_EN
        for (int i = 0; i < NP; i++) chk($sformatf("grant_count%0d", i), bus.grant_count[i*32 +: 32], m_cnt[i]);
`endif
        last_ready     = bus.req_ready;
        last_insert    = bus.rank_insert;
        last_fid       = bus.rank_flowID;
        last_remove    = bus.rank_remove;
        last_out_valid = bus.out_valid;
        last_out_rank  = bus.out_rank;
        ins_a  = bus.rank_insert;
        rem_a  = bus.rank_remove;
        fid_a  = bus.rank_flowID;
        meta_a = bus.rank_meta_wr;
        @(posedge clk);
        if (acc) m_full = 1'b0;
        if (e_rem) begin
            m_rank = sq[0].rank;
            m_meta = sq[0].meta;
            m_full = 1'b1;
        end
        if (rem_a && sq.size() > 0) head = sq.pop_front();
        if (ins_a) begin
            e.rank = fid_a;
            e.meta = meta_a;
            sq.push_back(e);
        end
        if (win >= 0) begin
            e.rank = fid[win];
            e.meta = meta[win];
            gold.push_back(e);
            m_ptr = (win + 1) % NP;
        end
`ifdef RANK_ARB_STATS_EN
        if (bus.stats_clr) begin
            for (int i = 0; i < NP; i++) m_cnt[i] = '0;
        end else if (win >= 0 && m_cnt[win] != 32'hFFFF_FFFF) begin
            m_cnt[win] = m_cnt[win] + 32'd1;
        end
`endif
        @(negedge clk);
    endtask

    task automatic drain();
        int w;
        int n;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((sq.size() > 0 || m_full) && n < 40) begin
            step(w);
            n++;
        end
        if (sq.size() > 0 || m_full) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0 t=%0t", sq.size(), $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        m_ptr  = 0;
        m_full = 1'b0;
        m_rank = '0;
        m_meta = '0;
        for (int i = 0; i < NP; i++) begin
            fid[i]  = FW'(16'h0A00 + i);
            meta[i] = MW'(16'h0B00 + i);
        end
`ifdef RANK_ARB_STATS_EN
        for (int i = 0; i < NP; i++) m_cnt[i] = '0;
        bus.stats_clr = 1'b0;
`endif
        bus.req_valid    = '1;
        bus.req_flowID   = '0;
        bus.req_meta     = '0;
        bus.rank_busy    = 1'b0;
        bus.rank_valid   = 1'b1;
        bus.rank_rank    = RW'(16'h1234);
        bus.rank_meta_rd = '0;
        bus.out_ready    = 1'b1;

        // reset values, with live inputs that would otherwise grant/remove
        #2;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_rank", bus.out_rank, '0);
        chk("rst_out_meta", bus.out_meta, '0);
        chk("rst_req_ready", bus.req_ready, '0);
        chk("rst_rank_insert", bus.rank_insert, 1'b0);
        chk("rst_rank_flowID", bus.rank_flowID, '0);
        chk("rst_rank_remove", bus.rank_remove, 1'b0);
        bus.req_valid  = '0;
        bus.rank_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // basic round-robin
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            step(w);
            chk("rr_flowID_lit", last_fid, 16'h0A00 + 16'(c % 4));
        end

        // back-pressure keeps port 2 waiting in place
        bus.req_valid = 4'b0100;
        bus.rank_busy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(w);
            chk("bp_insert_lit", last_insert, 1'b0);
        end
        bus.rank_busy = 1'b0;
        step(w);
        chk("bp_grant_lit", last_ready, 4'b0100);
        bus.req_valid = 4'b1111;
        step(w);
        chk("bp_ptr_lit", last_ready, 4'b1000);

        // skip idle ports with wrap
        bus.req_valid = 4'b0001;
        step(w);
        step(w);
        chk("wrap_grant_lit", last_ready, 4'b0001);
        bus.req_valid = 4'b1111;
        step(w);
        chk("wrap_ptr_lit", last_ready, 4'b0010);

        // drain with stall: exactly one pop, data held
        drain();
        preload(16'h0005, 16'h0055);
        preload(16'h0009, 16'h0099);
        bus.out_ready = 1'b0;
        step(w);
        chk("stall_first_remove_lit", last_remove, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(w);
            chk("stall_valid_lit", last_out_valid, 1'b1);
            chk("stall_rank_lit", last_out_rank, 16'h0005);
            chk("stall_no_remove_lit", last_remove, 1'b0);
        end

        // streaming ranks 1..8
        drain();
        for (int k = 1; k <= 8; k++) preload(RW'(k), MW'(16'h0100 + k));
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            step(w);
            if (c < 8) chk("stream_remove_lit", last_remove, 1'b1);
            if (c >= 1) chk("stream_rank_lit", last_out_rank, RW'(c));
        end

        // randomized traffic with requesters holding data until transfer
        for (int i = 0; i < NP; i++) begin
            fid[i]  = FW'($urandom);
            meta[i] = MW'($urandom);
        end
        bus.req_valid = '0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!bus.req_valid[i] && ($urandom_range(0, 1) == 1)) bus.req_valid[i] = 1'b1;
            end
            bus.rank_busy = ($urandom_range(0, 3) == 0) || (sq.size() >= 6);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            step(w);
            if (w >= 0) begin
                bus.req_valid[w] = 1'b0;
                fid[w]  = FW'($urandom);
                meta[w] = MW'($urandom);
            end
        end
        bus.rank_busy = 1'b0;

        // reset in the middle of a full slot with a pending head
        drain();
        preload(16'h0077, 16'h0707);
        bus.out_ready = 1'b0;
        step(w);
        preload(16'h0078, 16'h0808);
        bus.out_ready = 1'b1;
        drive_stage();
        #1;
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        chk("pre_rst_remove", bus.rank_remove, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_remove", bus.rank_remove, 1'b0);
        m_ptr  = 0;
        m_full = 1'b0;
        sq.delete();
        gold.delete();
`ifdef RANK_ARB_STATS_EN
        for (int i = 0; i < NP; i++) begin
            m_cnt[i] = '0;
            chk("mid_rst_count", bus.grant_count[i*32 +: 32], 32'd0);
        end
`endif
        drive_stage();
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        step(w);
        chk("post_rst_ptr_lit", last_ready, 4'b0001);

`ifdef RANK_ARB_STATS_EN
        // port 0 reaches 7 grants, then clear wins over a same-cycle grant
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 6; c++) step(w);
        chk("stats_seven_lit", bus.grant_count[31:0], 32'd7);
        bus.stats_clr = 1'b1;
        step(w);
        bus.stats_clr = 1'b0;
        bus.req_valid = '0;
        chk("stats_clr_lit", bus.grant_count[31:0], 32'd0);
        step(w);
`endif

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
